// File: rtl/cube_frame_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : cube_frame_uart_tx
//  Description : Streams one LED-cube frame over an 8N1 UART line. A frame is
//                the sync byte HEADER, FRAME_BYTES payload bytes read from an
//                external frame buffer (one-cycle read latency), and an 8-bit
//                modulo-256 checksum of the payload.
//  Ports       : clk_clk        - single clock, rising edge
//                reset_reset_n  - synchronous active-low reset
//                frame_start    - one-cycle request to send a frame
//                rd_addr[7:0]   - frame-buffer read address (payload index)
//                rd_data[7:0]   - frame-buffer read data, one cycle after addr
//                txd            - UART serial output, idle high, LSB first
//                busy           - frame in progress
//                done           - one-cycle pulse after final stop bit
//  Revision    : 1.0 - initial release
// ============================================================================
module cube_frame_uart_tx #(
   parameter int         CLKS_PER_BIT = 434,
   parameter int         FRAME_BYTES  = 64,
   parameter logic [7:0] HEADER       = 8'hA5
) (
   input  logic       clk_clk,
   input  logic       reset_reset_n,
   input  logic       frame_start,
   output logic [7:0] rd_addr,
   input  logic [7:0] rd_data,
   output logic       txd,
   output logic       busy,
   output logic       done
);

   localparam logic [2:0] c_IDLE  = 3'd0;
   localparam logic [2:0] c_FETCH = 3'd1;
   localparam logic [2:0] c_START = 3'd2;
   localparam logic [2:0] c_DATA  = 3'd3;
   localparam logic [2:0] c_STOP  = 3'd4;

   localparam logic [15:0] c_BAUD_LAST    = 16'(CLKS_PER_BIT - 1);
   // Byte slot numbering within a frame: 0 = header, 1..FRAME_BYTES = payload,
   // FRAME_BYTES+1 = checksum.
   localparam logic [8:0]  c_LAST_PAYLOAD = 9'(FRAME_BYTES);
   localparam logic [8:0]  c_LAST_BYTE    = 9'(FRAME_BYTES + 1);

   logic [2:0]  r_state;
   logic [15:0] r_baud;
   logic [2:0]  r_bit;
   logic [7:0]  r_shift;
   logic [7:0]  r_sum;
   logic [8:0]  r_byte;
   logic [7:0]  r_addr;
   logic        r_done;
   logic        w_baud_end;
   logic        w_txd;

   assign w_baud_end = (r_baud == c_BAUD_LAST);

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_state <= c_IDLE;
         r_baud  <= 16'd0;
         r_bit   <= 3'd0;
         r_shift <= 8'd0;
         r_sum   <= 8'd0;
         r_byte  <= 9'd0;
         r_addr  <= 8'd0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            c_IDLE: begin
               // A request coinciding with the done pulse is dropped so that
               // back-to-back frames always need a fresh request.
               if (frame_start && !r_done) begin
                  r_state <= c_START;
                  r_shift <= HEADER;
                  r_sum   <= 8'd0;
                  r_byte  <= 9'd0;
                  r_baud  <= 16'd0;
                  r_bit   <= 3'd0;
               end
            end

            c_START: begin
               if (w_baud_end) begin
                  r_baud  <= 16'd0;
                  r_state <= c_DATA;
               end else begin
                  r_baud <= r_baud + 16'd1;
               end
            end

            c_DATA: begin
               if (w_baud_end) begin
                  r_baud <= 16'd0;
                  if (r_bit == 3'd7) begin
                     r_bit   <= 3'd0;
                     r_state <= c_STOP;
                  end else begin
                     r_bit   <= r_bit + 3'd1;
                     r_shift <= {1'b0, r_shift[7:1]};
                  end
               end else begin
                  r_baud <= r_baud + 16'd1;
               end
            end

            c_STOP: begin
               if (w_baud_end) begin
                  r_baud <= 16'd0;
                  if (r_byte == c_LAST_BYTE) begin
                     r_state <= c_IDLE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= c_FETCH;
                     r_byte  <= r_byte + 9'd1;
                     // The next slot is payload index r_byte; the checksum
                     // slot needs no read, so the address simply holds.
                     if (r_byte < c_LAST_PAYLOAD) begin
                        r_addr <= r_byte[7:0];
                     end
                  end
               end else begin
                  r_baud <= r_baud + 16'd1;
               end
            end

            c_FETCH: begin
               // Cycle 0 presents the address, cycle 1 sees valid read data.
               if (r_baud == 16'd1) begin
                  r_baud  <= 16'd0;
                  r_state <= c_START;
                  if (r_byte <= c_LAST_PAYLOAD) begin
                     r_shift <= rd_data;
                     r_sum   <= r_sum + rd_data;
                  end else begin
                     r_shift <= r_sum;
                  end
               end else begin
                  r_baud <= r_baud + 16'd1;
               end
            end

            default: begin
               r_state <= c_IDLE;
               r_baud  <= 16'd0;
            end
         endcase
      end
   end

   always_comb begin
      w_txd = 1'b1;
      case (r_state)
         c_START: w_txd = 1'b0;
         c_DATA:  w_txd = r_shift[0];
         default: w_txd = 1'b1;
      endcase
   end

   assign txd     = w_txd;
   assign busy    = (r_state != c_IDLE);
   assign done    = r_done;
   assign rd_addr = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_cube_frame_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cube_frame_uart_tx
//  Description : Directed self-checking bench for cube_frame_uart_tx with
//                CLKS_PER_BIT=4 and FRAME_BYTES=4. A serial monitor decodes
//                txd into a byte queue with start-bit cycle stamps; a second
//                monitor counts done pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cube_frame_uart_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_start = 1'b0;
   logic [7:0] rd_addr;
   logic [7:0] rd_data = 8'h00;
   logic       txd;
   logic       busy;
   logic       done;

   logic [7:0] mem [4];
   int         cyc = 0;
   int         t_fs = 0;
   int         checks = 0;
   int         errors = 0;

   logic [7:0] byte_q [$];
   int         start_q [$];
   bit         frm_q [$];
   int         done_cnt = 0;
   int         done_cyc = 0;
   logic       busy_at_done = 1'b0;

   cube_frame_uart_tx #(
      .CLKS_PER_BIT (4),
      .FRAME_BYTES  (4),
      .HEADER       (8'hA5)
   ) dut (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .frame_start   (frame_start),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .txd           (txd),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Frame buffer with one cycle of read latency.
   always @(posedge clk) rd_data <= mem[rd_addr[1:0]];

   // Serial decoder: sampled 1 time unit after each rising edge.
   initial begin : rx_mon
      logic [7:0] d;
      int         st;
      bit         ok;
      bit         ab;
      int         bi;
      forever begin
         @(posedge clk); #1;
         if (rst_n === 1'b1 && txd === 1'b0) begin
            st = cyc; ok = 1'b1; ab = 1'b0; d = 8'h00;
            for (int s = 0; s < 40; s++) begin
               if (s > 0) begin
                  @(posedge clk); #1;
               end
               if (rst_n !== 1'b1) begin
                  ab = 1'b1;
                  break;
               end
               bi = s / 4;
               if (bi == 0) begin
                  if (txd !== 1'b0) ok = 1'b0;
               end else if (bi == 9) begin
                  if (txd !== 1'b1) ok = 1'b0;
               end else if (s % 4 == 0) begin
                  d[bi-1] = txd;
               end else if (txd !== d[bi-1]) begin
                  ok = 1'b0;
               end
            end
            if (!ab) begin
               byte_q.push_back(d);
               start_q.push_back(st);
               frm_q.push_back(ok);
            end
         end
      end
   end

   initial begin : done_mon
      forever begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            busy_at_done = busy;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic clear_mon();
      byte_q.delete();
      start_q.delete();
      frm_q.delete();
      done_cnt = 0;
   endtask

   // Pulse frame_start for one cycle; t_fs is the edge that samples it, so
   // the first start bit is expected in the cycle right after edge t_fs.
   task automatic pulse_start();
      @(negedge clk);
      frame_start = 1'b1;
      t_fs = cyc + 1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      int n;
      n = 0;
      while (done_cnt == 0 && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", done_cnt, 1);
   endtask

   task automatic load_mem(input logic [31:0] v);
      mem[0] = v[31:24];
      mem[1] = v[23:16];
      mem[2] = v[15:8];
      mem[3] = v[7:0];
   endtask

   // Expected bytes packed MSB-first: byte k is exp[47-8k -: 8].
   task automatic check_frame(input string tag, input logic [47:0] exp);
      int bad_frm;
      int bad_sp;
      chk($sformatf("%s_nbytes", tag), byte_q.size(), 6);
      bad_frm = 0;
      bad_sp  = 0;
      for (int k = 0; k < 6; k++) begin
         if (k < byte_q.size()) begin
            chk($sformatf("%s_byte%0d", tag, k), {24'd0, byte_q[k]}, {24'd0, exp[47-8*k -: 8]});
            if (!frm_q[k]) bad_frm++;
            if (start_q[k] != t_fs + 42 * k) bad_sp++;
         end
      end
      chk($sformatf("%s_framing_errs", tag), bad_frm, 0);
      chk($sformatf("%s_spacing_errs", tag), bad_sp, 0);
      chk($sformatf("%s_done_cycle", tag), done_cyc, t_fs + 250);
      chk($sformatf("%s_busy_at_done", tag), {31'd0, busy_at_done}, 0);
      chk($sformatf("%s_done_count", tag), done_cnt, 1);
   endtask

   initial begin : stim
      int bad;
      load_mem(32'h00000000);

      // Reset with a simultaneous frame request that must be ignored.
      frame_start = 1'b1;
      tick(3);
      chk("rst_txd", {31'd0, txd}, 1);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_rd_addr", {24'd0, rd_addr}, 0);
      frame_start = 1'b0;
      rst_n = 1'b1;

      // Line idle for 1000 cycles.
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rd_addr !== 8'h00) bad++;
      end
      chk("idle_bad_cycles", bad, 0);
      chk("idle_no_bytes", byte_q.size(), 0);

      // Basic frame.
      clear_mon();
      load_mem(32'h01020304);
      pulse_start();
      chk("t1_txd_low", {31'd0, txd}, 0);
      chk("t1_busy_high", {31'd0, busy}, 1);
      wait_done(400);
      tick(5);
      check_frame("basic", 48'hA5_01_02_03_04_0A);
      chk("basic_rd_addr_hold", {24'd0, rd_addr}, 3);

      // Checksum wraps modulo 256.
      tick(10);
      clear_mon();
      load_mem(32'hFFFFFF03);
      pulse_start();
      wait_done(400);
      tick(5);
      check_frame("wrap", 48'hA5_FF_FF_FF_03_00);

      // Requests during the frame and on the done cycle are ignored.
      tick(10);
      clear_mon();
      load_mem(32'h10203040);
      pulse_start();
      wait_cyc(t_fs + 2 * 42 + 10);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      wait_cyc(t_fs + 250);
      chk("ign_done_now", {31'd0, done}, 1);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      chk("ign_busy_after_done", {31'd0, busy}, 0);
      tick(60);
      check_frame("ignore", 48'hA5_10_20_30_40_A0);
      chk("ign_txd_idle", {31'd0, txd}, 1);

      // Reset during the data bits of the third payload byte.
      clear_mon();
      load_mem(32'h01020304);
      pulse_start();
      wait_cyc(t_fs + 140);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mid_rst_txd", {31'd0, txd}, 1);
      chk("mid_rst_busy", {31'd0, busy}, 0);
      chk("mid_rst_done", {31'd0, done}, 0);
      tick(100);
      chk("mid_rst_no_done", done_cnt, 0);
      chk("mid_rst_partial_bytes", byte_q.size(), 3);
      clear_mon();
      pulse_start();
      wait_done(400);
      tick(5);
      check_frame("after_rst", 48'hA5_01_02_03_04_0A);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cube_frame_uart_tx.md
CUBE_FRAME_UART_TX -- requirements
Module: cube_frame_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, SHALL set clock cycles per UART bit (50 MHz / 115200 baud); legal range 4..65535.
REQ-002 Parameter FRAME_BYTES, default 64, SHALL set payload bytes per frame (8x8x8 cube, 1 bit per LED); legal range 1..256.
REQ-003 Parameter HEADER, default 8'hA5, SHALL set the sync byte sent before the payload.
REQ-004 clk_clk  input  1  SHALL be the single clock; all logic on its rising edge.
REQ-005 reset_reset_n  input  1  SHALL be the synchronous, active-low reset.
REQ-006 frame_start  input  1  SHALL be the one-cycle request to transmit one frame.
REQ-007 rd_addr  output  8  SHALL be the frame-buffer read address (payload index 0..FRAME_BYTES-1).
REQ-008 rd_data  input  8  SHALL be the frame-buffer read data, valid exactly one cycle after rd_addr changes.
REQ-009 txd  output  1  SHALL be the UART serial output, 8N1, LSB first, idle high.
REQ-010 busy  output  1  SHALL be high from the cycle after an accepted frame_start until the cycle done pulses.
REQ-011 done  output  1  SHALL pulse high for one cycle when the final stop bit of a frame completes.

Function
REQ-012 Each frame SHALL be HEADER, then payload bytes at rd_addr 0..FRAME_BYTES-1 in order, then one checksum byte: FRAME_BYTES+2 bytes in total.
REQ-013 Checksum SHALL be the 8-bit sum, modulo 256, of all payload bytes; it excludes HEADER, and carries out of bit 7 are discarded.
REQ-014 FSM states SHALL be IDLE, FETCH, START, DATA, STOP.
- IDLE -> START on frame_start, with the header byte loaded.
- START -> DATA after CLKS_PER_BIT cycles.
- DATA -> STOP after 8 bits.
- STOP -> FETCH if bytes remain; STOP -> IDLE after the checksum byte.
- FETCH -> START after the rd_data latency.
REQ-015 START SHALL drive txd=0, DATA SHALL drive shift-register bit 0 with bit index 0..7, and STOP SHALL drive txd=1; each bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-016 FETCH SHALL present rd_addr, capture rd_data on the following cycle into the shift register and the checksum accumulator, and then enter START: exactly 2 idle-high cycles between one stop bit and the next start bit.
REQ-017 Byte-to-byte spacing SHALL be 10*CLKS_PER_BIT+2 cycles for payload and checksum bytes; the header-to-first-payload gap SHALL also include the 2 FETCH cycles.
REQ-018 The first start bit SHALL appear on txd 1 cycle after frame_start is sampled in IDLE.
REQ-019 frame_start while busy=1 SHALL be ignored, with no queuing, and frame_start on the same cycle as done SHALL also be ignored.
REQ-020 rd_addr SHALL hold its last value outside FETCH and SHALL never exceed FRAME_BYTES-1.
REQ-021 The checksum accumulator SHALL clear on every accepted frame_start.
REQ-022 The baud counter SHALL be at least 16 bits wide and wrap to 0 at CLKS_PER_BIT-1, with no drift across bits.

Reset
REQ-023 While reset_reset_n=0 on a clock edge, the next state SHALL be: FSM IDLE, txd=1, busy=0, done=0, rd_addr=0, checksum=0, baud counter=0, bit index=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame: txd=1 on the cycle after the reset edge, done SHALL NOT pulse, and the first frame_start after reset release SHALL start a fresh frame beginning with HEADER.
REQ-025 frame_start sampled in the same cycle as reset_reset_n=0 SHALL be ignored.

Verification (bench uses CLKS_PER_BIT=4, FRAME_BYTES=4)
REQ-026 Basic frame: buffer {01,02,03,04}, frame_start pulse -> txd serial bytes A5,01,02,03,04,0A, each with start=0 and stop=1, and each bit held exactly 4 cycles.
REQ-027 Checksum wrap: buffer {FF,FF,FF,03} -> checksum byte 8'h00 (sum 0x300 mod 256).
REQ-028 Timing: frame_start at cycle T -> txd falls at T+1, busy high at T+1, done pulses at T+1+6*40+5*2 = T+251, and busy is low at T+251.
REQ-029 Ignored request: second frame_start during payload byte 2 -> exactly 6 bytes sent and a single done pulse; frame_start asserted on the done cycle -> no new frame.
REQ-030 Reset mid-frame: reset_reset_n=0 for 1 cycle during the DATA bits of byte 3 -> txd=1 on the next cycle, busy=0, no done; a following frame_start -> full correct frame A5,...,0A.
REQ-031 Line idle: no frame_start for 1000 cycles after reset -> txd constantly 1, busy=0, done=0, rd_addr=0.
